riscv_core_dcache_axi_responder: RTL and testbench
==================================================

Name: riscv_core_dcache_axi_responder

Overview:
- Memory-side end of the data-cache miss/store interface: accepts the cache controller's block-refill read requests and single-doubleword store requests.
- Converts them into AXI4 master transactions: a 4-beat INCR read burst for a refill, a 1-beat write for a store.
- Returns the assembled 256-bit block or a write completion as a one-cycle done pulse.
- Sits between the dcache top and the SoC AXI interconnect.

Parameters:
ADDR_WIDTH, 64, address width of cache and AXI sides
CORE_DATA_WIDTH, 64, AXI data-bus and store data width
AXI_DATA_WIDTH, 256, cache block width; BEATS = AXI_DATA_WIDTH/CORE_DATA_WIDTH = 4

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_mem_read_req  in  1  refill request, level, held until o_mem_read_done
i_mem_read_address  in  ADDR_WIDTH  refill address, any byte in block
o_mem_read_done  out  1  one-cycle pulse, o_block_to_cache valid
o_block_to_cache  out  AXI_DATA_WIDTH  assembled block, held until next refill completes
i_mem_write_valid  in  1  store request, level, held until o_mem_write_done
i_mem_write_address  in  ADDR_WIDTH  store address (doubleword-aligned)
i_mem_write_data  in  CORE_DATA_WIDTH  store data
i_mem_write_strobe  in  8  byte enables
o_mem_write_done  out  1  one-cycle pulse, store acknowledged by B channel
o_bus_error  out  1  sticky; set on non-OKAY resp or beat-count mismatch; cleared only by reset
o_axi_araddr  out  ADDR_WIDTH  block-aligned read address
o_axi_arlen  out  8  constant BEATS-1
o_axi_arvalid  out  1  AR valid
i_axi_arready  in  1  AR ready
i_axi_rdata  in  CORE_DATA_WIDTH  read data
i_axi_rresp  in  2  read response
i_axi_rlast  in  1  last beat
i_axi_rvalid  in  1  R valid
o_axi_rready  out  1  R ready
o_axi_awaddr  out  ADDR_WIDTH  write address
o_axi_awvalid  out  1  AW valid
i_axi_awready  in  1  AW ready
o_axi_wdata  out  CORE_DATA_WIDTH  write data
o_axi_wstrb  out  8  write strobe
o_axi_wvalid  out  1  W valid (WLAST tied 1 at SoC top)
i_axi_wready  in  1  W ready
i_axi_bresp  in  2  write response
i_axi_bvalid  in  1  B valid
o_axi_bready  out  1  B ready

Behaviour:
- Reset (async, any state): state IDLE; all valid/ready/done outputs 0; o_block_to_cache 0; o_bus_error 0; beat counter 0. Outstanding AXI transaction is abandoned; interconnect is reset in the same domain.
- ARSIZE=3 and burst=INCR are fixed system-wide.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: if i_mem_write_valid, latch addr/data/strobe and go to WR_REQ. Else if i_mem_read_req, latch addr and go to RD_ADDR. Write wins when both are asserted in the same cycle.
- RD_ADDR: arvalid=1, araddr={addr[63:5],5'b0}. Hold stable until arready, then go to RD_DATA with counter=0.
- RD_DATA: rready=1. Each rvalid beat writes block[64*cnt +: 64] and increments cnt.
  - Beat with rlast: if cnt!=BEATS-1, or rresp!=0 on any beat, set o_bus_error.
  - On rlast, go to DONE and pulse o_mem_read_done.
  - A beat with cnt==BEATS-1 but no rlast sets error; further beats are dropped until rlast.
- WR_REQ: awvalid and wvalid both asserted in the first cycle. Each deasserts independently on its own handshake; both may complete in the same cycle. When both are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, set error if bresp!=0, go to DONE, pulse o_mem_write_done.
- DONE: exactly one cycle. The done pulse is registered and coincides with DONE. Return to IDLE without sampling requests, since the requester deasserts on done.
- Latency with zero-wait AXI:
  - Refill: AR in cycle 1, beats in cycles 2-5, done in cycle 6.
  - Store: AW/W in cycle 1, B in cycle 2, done in cycle 3.
- Request inputs are ignored outside IDLE. Changing them mid-transaction has no effect.

Decomposition:
- Package riscv_core_dcache_pkg:
  - FSM state enum.
  - AXI resp constants: OKAY=2'b00.
  - BEATS and BLOCK_ALIGN_BITS=5.
  - Fixed ARSIZE/ARBURST encodings.
- Optional sub-module riscv_core_dcache_beat_assembler: beat counter plus 256-bit shift/index register with error check. Otherwise flat.

Test Plan:
- Refill at 0x1008, zero-wait AXI, beats 0x11..,0x22..,0x33..,0x44.. → araddr=0x1000, arlen=3, block={beat3,beat2,beat1,beat0}, done pulse in cycle 6, error=0.
- Store at 0x2010, data 0xDEADBEEF_CAFEF00D, strobe 0x0F; awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 3, single done pulse after B.
- Read and write asserted in the same IDLE cycle → write completes first, then read issues after DONE/IDLE.
- rresp=SLVERR on beat 2 → all 4 beats are still captured, done pulses, o_bus_error stays 1 through later clean transactions.
- rlast on beat 2 (early) → done on that beat, o_bus_error=1, FSM back in IDLE.
- Assert i_rst_n low during RD_DATA beat 1 → all outputs 0 immediately (asynchronously); a fresh refill after reset completes normally.

Source files
------------

// File: rtl/riscv_core_dcache_pkg.sv
// Shared types and constants for the dcache AXI responder:
// FSM encoding, AXI response codes and block geometry.
package riscv_core_dcache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam int unsigned BEATS            = 4;
    localparam int unsigned BLOCK_ALIGN_BITS = 5;

    // Fixed system-wide: 8-byte beats, incrementing bursts.
    localparam logic [2:0]  AXI_ARSIZE       = 3'd3;
    localparam logic [1:0]  AXI_BURST_INCR   = 2'b01;

endpackage

// File: rtl/riscv_core_dcache_axi_responder_if.sv
// Cache-side request/response and AXI4 master signals of the responder.
// master = responder view, slave = cache controller plus interconnect view.
interface riscv_core_dcache_axi_responder_if #(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned CORE_DATA_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH  = 256
);
    logic                       i_mem_read_req;
    logic [ADDR_WIDTH-1:0]      i_mem_read_address;
    logic                       o_mem_read_done;
    logic [AXI_DATA_WIDTH-1:0]  o_block_to_cache;
    logic                       i_mem_write_valid;
    logic [ADDR_WIDTH-1:0]      i_mem_write_address;
    logic [CORE_DATA_WIDTH-1:0] i_mem_write_data;
    logic [7:0]                 i_mem_write_strobe;
    logic                       o_mem_write_done;
    logic                       o_bus_error;

    logic [ADDR_WIDTH-1:0]      o_axi_araddr;
    logic [7:0]                 o_axi_arlen;
    logic                       o_axi_arvalid;
    logic                       i_axi_arready;
    logic [CORE_DATA_WIDTH-1:0] i_axi_rdata;
    logic [1:0]                 i_axi_rresp;
    logic                       i_axi_rlast;
    logic                       i_axi_rvalid;
    logic                       o_axi_rready;
    logic [ADDR_WIDTH-1:0]      o_axi_awaddr;
    logic                       o_axi_awvalid;
    logic                       i_axi_awready;
    logic [CORE_DATA_WIDTH-1:0] o_axi_wdata;
    logic [7:0]                 o_axi_wstrb;
    logic                       o_axi_wvalid;
    logic                       i_axi_wready;
    logic [1:0]                 i_axi_bresp;
    logic                       i_axi_bvalid;
    logic                       o_axi_bready;

    modport master (
        input  i_mem_read_req, i_mem_read_address,
        input  i_mem_write_valid, i_mem_write_address, i_mem_write_data, i_mem_write_strobe,
        output o_mem_read_done, o_block_to_cache, o_mem_write_done, o_bus_error,
        output o_axi_araddr, o_axi_arlen, o_axi_arvalid, input i_axi_arready,
        input  i_axi_rdata, i_axi_rresp, i_axi_rlast, i_axi_rvalid, output o_axi_rready,
        output o_axi_awaddr, o_axi_awvalid, input i_axi_awready,
        output o_axi_wdata, o_axi_wstrb, o_axi_wvalid, input i_axi_wready,
        input  i_axi_bresp, i_axi_bvalid, output o_axi_bready
    );

    modport slave (
        output i_mem_read_req, i_mem_read_address,
        output i_mem_write_valid, i_mem_write_address, i_mem_write_data, i_mem_write_strobe,
        input  o_mem_read_done, o_block_to_cache, o_mem_write_done, o_bus_error,
        input  o_axi_araddr, o_axi_arlen, o_axi_arvalid, output i_axi_arready,
        output i_axi_rdata, i_axi_rresp, i_axi_rlast, i_axi_rvalid, input o_axi_rready,
        input  o_axi_awaddr, o_axi_awvalid, output i_axi_awready,
        input  o_axi_wdata, o_axi_wstrb, o_axi_wvalid, output i_axi_wready,
        output i_axi_bresp, i_axi_bvalid, input o_axi_bready
    );

endinterface

// File: rtl/riscv_core_dcache_beat_assembler.sv
// Collects read-burst beats into a cache block and flags malformed bursts.
// The published block only changes when the beat carrying rlast arrives.
module riscv_core_dcache_beat_assembler
    import riscv_core_dcache_pkg::*;
#(
    parameter int unsigned CORE_DATA_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH  = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       beat_valid,
    input  logic [CORE_DATA_WIDTH-1:0] beat_data,
    input  logic [1:0]                 beat_resp,
    input  logic                       beat_last,
    output logic [AXI_DATA_WIDTH-1:0]  block,
    output logic                       beat_error
);

    logic [2:0]                cnt;
    logic [AXI_DATA_WIDTH-1:0] buffer;
    logic [AXI_DATA_WIDTH-1:0] merged;

    // Beats past the block end leave the buffer untouched.
    always_comb begin
        merged = buffer;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (cnt == 3'(i)) merged[i*CORE_DATA_WIDTH +: CORE_DATA_WIDTH] = beat_data;
        end
    end

    always_comb begin
        beat_error = 1'b0;
        if (beat_valid) begin
            if (beat_resp != AXI_RESP_OKAY)               beat_error = 1'b1;
            if (beat_last  && cnt != 3'(BEATS - 1))       beat_error = 1'b1;
            if (!beat_last && cnt == 3'(BEATS - 1))       beat_error = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            buffer <= '0;
            block  <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (beat_valid) begin
            buffer <= merged;
            if (cnt < 3'(BEATS)) cnt <= cnt + 3'd1;
            if (beat_last)       block <= merged;
        end
    end

endmodule

// File: rtl/riscv_core_dcache_axi_responder.sv
// Turns dcache refill/store requests into AXI4 read bursts and single writes,
// returning the block or a store acknowledge as a one-cycle done pulse.
module riscv_core_dcache_axi_responder
    import riscv_core_dcache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned CORE_DATA_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH  = 256
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    riscv_core_dcache_axi_responder_if.master bus
);

    state_t                     state, state_next;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [CORE_DATA_WIDTH-1:0] wdata;
    logic [7:0]                 wstrb;
    logic                       is_write, aw_done, w_done, bus_error;
    logic                       ar_hs, aw_hs, w_hs, b_hs, r_beat, beat_error;

    assign ar_hs  = (state == RD_ADDR) && bus.i_axi_arready;
    assign aw_hs  = (state == WR_REQ) && !aw_done && bus.i_axi_awready;
    assign w_hs   = (state == WR_REQ) && !w_done && bus.i_axi_wready;
    assign b_hs   = (state == WR_RESP) && bus.i_axi_bvalid;
    assign r_beat = (state == RD_DATA) && bus.i_axi_rvalid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.i_mem_write_valid)   state_next = WR_REQ;
                else if (bus.i_mem_read_req) state_next = RD_ADDR;
            end
            RD_ADDR: if (bus.i_axi_arready) state_next = RD_DATA;
            RD_DATA: if (bus.i_axi_rvalid && bus.i_axi_rlast) state_next = DONE;
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_RESP;
            WR_RESP: if (bus.i_axi_bvalid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.o_axi_arvalid    = (state == RD_ADDR);
        bus.o_axi_rready     = (state == RD_DATA);
        bus.o_axi_awvalid    = (state == WR_REQ) && !aw_done;
        bus.o_axi_wvalid     = (state == WR_REQ) && !w_done;
        bus.o_axi_bready     = (state == WR_RESP);
        bus.o_mem_read_done  = (state == DONE) && !is_write;
        bus.o_mem_write_done = (state == DONE) && is_write;
    end

    // Request fields are captured only in IDLE so mid-transaction changes are ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            is_write  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (bus.i_mem_write_valid) begin
                    addr     <= bus.i_mem_write_address;
                    wdata    <= bus.i_mem_write_data;
                    wstrb    <= bus.i_mem_write_strobe;
                    is_write <= 1'b1;
                end else if (bus.i_mem_read_req) begin
                    addr     <= bus.i_mem_read_address;
                    is_write <= 1'b0;
                end
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (beat_error || (b_hs && bus.i_axi_bresp != AXI_RESP_OKAY)) bus_error <= 1'b1;
        end
    end

    riscv_core_dcache_beat_assembler #(
        .CORE_DATA_WIDTH (CORE_DATA_WIDTH),
        .AXI_DATA_WIDTH  (AXI_DATA_WIDTH)
    ) u_beat_assembler (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .start      (ar_hs),
        .beat_valid (r_beat),
        .beat_data  (bus.i_axi_rdata),
        .beat_resp  (bus.i_axi_rresp),
        .beat_last  (bus.i_axi_rlast),
        .block      (bus.o_block_to_cache),
        .beat_error (beat_error)
    );

    assign bus.o_axi_araddr = {addr[ADDR_WIDTH-1:BLOCK_ALIGN_BITS], {BLOCK_ALIGN_BITS{1'b0}}};
    assign bus.o_axi_arlen  = 8'(BEATS - 1);
    assign bus.o_axi_awaddr = addr;
    assign bus.o_axi_wdata  = wdata;
    assign bus.o_axi_wstrb  = wstrb;
    assign bus.o_bus_error  = bus_error;

endmodule

// File: tb/tb_riscv_core_dcache_axi_responder.sv
// Directed bench for the dcache AXI responder: refills, stores, arbitration,
// error stickiness and asynchronous reset, with hand-computed expectations.
module tb_riscv_core_dcache_axi_responder;

    logic        clk;
    logic        rst_n;
    int unsigned compared;
    int unsigned mismatched;

    riscv_core_dcache_axi_responder_if bus ();

    riscv_core_dcache_axi_responder dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic [1:0] r, input logic l);
        bus.i_axi_rvalid = 1'b1;
        bus.i_axi_rdata  = d;
        bus.i_axi_rresp  = r;
        bus.i_axi_rlast  = l;
        cyc();
    endtask

    task automatic idle_inputs();
        bus.i_mem_read_req      = 1'b0;
        bus.i_mem_read_address  = '0;
        bus.i_mem_write_valid   = 1'b0;
        bus.i_mem_write_address = '0;
        bus.i_mem_write_data    = '0;
        bus.i_mem_write_strobe  = '0;
        bus.i_axi_arready       = 1'b1;
        bus.i_axi_rdata         = '0;
        bus.i_axi_rresp         = 2'b00;
        bus.i_axi_rlast         = 1'b0;
        bus.i_axi_rvalid        = 1'b0;
        bus.i_axi_awready       = 1'b1;
        bus.i_axi_wready        = 1'b1;
        bus.i_axi_bresp         = 2'b00;
        bus.i_axi_bvalid        = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        idle_inputs();
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // Reset state
        chk("rst_valids", {bus.o_axi_arvalid, bus.o_axi_rready, bus.o_axi_awvalid,
                           bus.o_axi_wvalid, bus.o_axi_bready}, 0);
        chk("rst_dones", {bus.o_mem_read_done, bus.o_mem_write_done}, 0);
        chk("rst_block", bus.o_block_to_cache, 0);
        chk("rst_err", bus.o_bus_error, 0);

        // Refill at 0x1008, zero-wait
        bus.i_mem_read_req     = 1'b1;
        bus.i_mem_read_address = 64'h1008;
        cyc();
        chk("rf_arvalid", bus.o_axi_arvalid, 1);
        chk("rf_araddr", bus.o_axi_araddr, 64'h1000);
        chk("rf_arlen", bus.o_axi_arlen, 3);
        cyc();
        chk("rf_rready", {bus.o_axi_arvalid, bus.o_axi_rready}, 2'b01);
        beat(64'h1111111111111111, 2'b00, 1'b0);
        beat(64'h2222222222222222, 2'b00, 1'b0);
        beat(64'h3333333333333333, 2'b00, 1'b0);
        chk("rf_done_c5", bus.o_mem_read_done, 0);
        beat(64'h4444444444444444, 2'b00, 1'b1);
        chk("rf_done_c6", bus.o_mem_read_done, 1);
        chk("rf_block", bus.o_block_to_cache,
            {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111});
        chk("rf_err", bus.o_bus_error, 0);
        idle_inputs();
        cyc();
        chk("rf_done_c7", bus.o_mem_read_done, 0);

        // Store at 0x2010, awready delayed to the third cycle
        bus.i_mem_write_valid   = 1'b1;
        bus.i_mem_write_address = 64'h2010;
        bus.i_mem_write_data    = 64'hDEADBEEF_CAFEF00D;
        bus.i_mem_write_strobe  = 8'h0F;
        bus.i_axi_awready       = 1'b0;
        cyc();
        chk("st_c1_valids", {bus.o_axi_awvalid, bus.o_axi_wvalid}, 2'b11);
        chk("st_awaddr", bus.o_axi_awaddr, 64'h2010);
        chk("st_wdata", bus.o_axi_wdata, 64'hDEADBEEF_CAFEF00D);
        chk("st_wstrb", bus.o_axi_wstrb, 8'h0F);
        cyc();
        chk("st_c2_valids", {bus.o_axi_awvalid, bus.o_axi_wvalid}, 2'b10);
        cyc();
        chk("st_c3_valids", {bus.o_axi_awvalid, bus.o_axi_wvalid}, 2'b10);
        bus.i_axi_awready = 1'b1;
        cyc();
        chk("st_c4_resp", {bus.o_axi_awvalid, bus.o_axi_bready, bus.o_mem_write_done}, 3'b010);
        bus.i_axi_bvalid = 1'b1;
        cyc();
        chk("st_done", {bus.o_mem_write_done, bus.o_mem_read_done}, 2'b10);
        idle_inputs();
        cyc();
        chk("st_done_after", bus.o_mem_write_done, 0);
        chk("st_err", bus.o_bus_error, 0);

        // Simultaneous write and read: write first
        bus.i_mem_write_valid   = 1'b1;
        bus.i_mem_write_address = 64'h4000;
        bus.i_mem_write_data    = 64'h0123456789ABCDEF;
        bus.i_mem_write_strobe  = 8'hFF;
        bus.i_mem_read_req      = 1'b1;
        bus.i_mem_read_address  = 64'h3018;
        cyc();
        chk("both_wr_first", {bus.o_axi_awvalid, bus.o_axi_wvalid, bus.o_axi_arvalid}, 3'b110);
        chk("both_awaddr", bus.o_axi_awaddr, 64'h4000);
        cyc();
        bus.i_axi_bvalid = 1'b1;
        cyc();
        chk("both_wdone", {bus.o_mem_write_done, bus.o_mem_read_done}, 2'b10);
        bus.i_mem_write_valid = 1'b0;
        bus.i_axi_bvalid      = 1'b0;
        cyc();
        chk("both_idle", bus.o_axi_arvalid, 0);
        cyc();
        chk("both_arvalid", bus.o_axi_arvalid, 1);
        chk("both_araddr", bus.o_axi_araddr, 64'h3000);
        cyc();
        beat(64'h5555555555555555, 2'b00, 1'b0);
        beat(64'h6666666666666666, 2'b00, 1'b0);
        beat(64'h7777777777777777, 2'b00, 1'b0);
        beat(64'h8888888888888888, 2'b00, 1'b1);
        chk("both_rdone", {bus.o_mem_read_done, bus.o_mem_write_done}, 2'b10);
        chk("both_block", bus.o_block_to_cache,
            {64'h8888888888888888, 64'h7777777777777777, 64'h6666666666666666, 64'h5555555555555555});
        idle_inputs();
        cyc();

        // Early rlast on the third beat
        bus.i_mem_read_req     = 1'b1;
        bus.i_mem_read_address = 64'h9040;
        cyc();
        chk("early_araddr", bus.o_axi_araddr, 64'h9040);
        cyc();
        beat(64'hAAAAAAAAAAAAAAAA, 2'b00, 1'b0);
        beat(64'hBBBBBBBBBBBBBBBB, 2'b00, 1'b0);
        chk("early_err_before", bus.o_bus_error, 0);
        beat(64'hCCCCCCCCCCCCCCCC, 2'b00, 1'b1);
        chk("early_done", bus.o_mem_read_done, 1);
        chk("early_block_lo", bus.o_block_to_cache[191:0],
            {64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA});
        chk("early_err", bus.o_bus_error, 1);
        idle_inputs();
        cyc();
        chk("early_idle", {bus.o_mem_read_done, bus.o_axi_arvalid, bus.o_axi_rready}, 0);

        // Asynchronous reset while the second beat is presented
        bus.i_mem_read_req     = 1'b1;
        bus.i_mem_read_address = 64'h5020;
        cyc();
        cyc();
        beat(64'hD0D0D0D0D0D0D0D0, 2'b00, 1'b0);
        bus.i_axi_rdata = 64'hD1D1D1D1D1D1D1D1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valids", {bus.o_axi_arvalid, bus.o_axi_rready, bus.o_axi_awvalid,
                            bus.o_axi_wvalid, bus.o_axi_bready}, 0);
        chk("arst_dones", {bus.o_mem_read_done, bus.o_mem_write_done}, 0);
        chk("arst_block", bus.o_block_to_cache, 0);
        chk("arst_err", bus.o_bus_error, 0);
        idle_inputs();
        #3 rst_n = 1'b1;
        cyc();
        bus.i_mem_read_req     = 1'b1;
        bus.i_mem_read_address = 64'h6038;
        cyc();
        chk("post_rst_araddr", bus.o_axi_araddr, 64'h6020);
        cyc();
        beat(64'h0102030405060708, 2'b00, 1'b0);
        beat(64'h1112131415161718, 2'b00, 1'b0);
        beat(64'h2122232425262728, 2'b00, 1'b0);
        beat(64'h3132333435363738, 2'b00, 1'b1);
        chk("post_rst_done", bus.o_mem_read_done, 1);
        chk("post_rst_block", bus.o_block_to_cache,
            {64'h3132333435363738, 64'h2122232425262728, 64'h1112131415161718, 64'h0102030405060708});
        chk("post_rst_err", bus.o_bus_error, 0);
        idle_inputs();
        cyc();

        // SLVERR on the third beat: block still assembled, error sticky
        bus.i_mem_read_req     = 1'b1;
        bus.i_mem_read_address = 64'h7000;
        cyc();
        cyc();
        beat(64'hE0E0E0E0E0E0E0E0, 2'b00, 1'b0);
        beat(64'hE1E1E1E1E1E1E1E1, 2'b00, 1'b0);
        beat(64'hE2E2E2E2E2E2E2E2, 2'b10, 1'b0);
        beat(64'hE3E3E3E3E3E3E3E3, 2'b00, 1'b1);
        chk("slverr_done", bus.o_mem_read_done, 1);
        chk("slverr_block", bus.o_block_to_cache,
            {64'hE3E3E3E3E3E3E3E3, 64'hE2E2E2E2E2E2E2E2, 64'hE1E1E1E1E1E1E1E1, 64'hE0E0E0E0E0E0E0E0});
        chk("slverr_err", bus.o_bus_error, 1);
        idle_inputs();
        cyc();
        bus.i_mem_write_valid   = 1'b1;
        bus.i_mem_write_address = 64'h8008;
        bus.i_mem_write_data    = 64'h0102030405060708;
        bus.i_mem_write_strobe  = 8'hFF;
        cyc();
        cyc();
        bus.i_axi_bvalid = 1'b1;
        cyc();
        chk("sticky_wdone", bus.o_mem_write_done, 1);
        idle_inputs();
        cyc();
        chk("sticky_err", bus.o_bus_error, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
